// File: rtl/axi_node_pkg.sv
// Shared types and defaults for the AXI node exclusive-access lock logic.
`default_nettype none

package axi_node_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned ID_WIDTH_DEFAULT = 16;

endpackage : axi_node_pkg

`default_nettype wire

// File: rtl/axi_lock_timer.sv
// Saturating lock-duration counter; expired flags the last allowed LOCKED cycle.
`default_nettype none

module axi_lock_timer
  import axi_node_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == LAST);

endmodule : axi_lock_timer

`default_nettype wire

// File: rtl/axi_excl_lock_ctrl.sv
// Exclusive-access lock controller steering a 2-input request arbiter.
`default_nettype none

module axi_excl_lock_ctrl
  import axi_node_pkg::*;
#(
  parameter int unsigned ID_WIDTH = ID_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                data_req0_i,
  input  logic                data_req1_i,
  input  logic                data_excl0_i,
  input  logic                data_excl1_i,
  input  logic [ID_WIDTH-1:0] data_ID0_i,
  input  logic [ID_WIDTH-1:0] data_ID1_i,
  input  logic                data_gnt0_i,
  input  logic                data_gnt1_i,
  input  logic                rsp_valid_i,
  input  logic                rsp_ready_i,
  input  logic [ID_WIDTH-1:0] rsp_ID_i,
  output logic                RR_FLAG_o,
  output logic                lock_EXCLUSIVE_o,
  output logic                SEL_EXCLUSIVE_o,
  output logic                timeout_o
);

  lock_state_e         state;
  logic [ID_WIDTH-1:0] lock_id;
  logic                rsp_match;
  logic                expired;
  logic                unused_req;

  // Requests are already folded into the arbiter's grants.
  assign unused_req = &{1'b0, data_req0_i, data_req1_i};

  assign rsp_match = rsp_valid_i & rsp_ready_i & (rsp_ID_i == lock_id);

  axi_lock_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (state == LOCKED),
    .expired (expired)
  );

  // An exclusive grant leaves RR_FLAG alone: the release re-points it at the
  // other channel anyway. Channel 0 wins when both grants are (illegally) set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      RR_FLAG_o       <= 1'b0;
      SEL_EXCLUSIVE_o <= 1'b0;
      timeout_o       <= 1'b0;
      lock_id         <= '0;
    end else begin
      timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (data_gnt0_i) begin
            if (data_excl0_i) begin
              state           <= LOCKED;
              SEL_EXCLUSIVE_o <= 1'b0;
              lock_id         <= data_ID0_i;
            end else begin
              RR_FLAG_o <= 1'b1;
            end
          end else if (data_gnt1_i) begin
            if (data_excl1_i) begin
              state           <= LOCKED;
              SEL_EXCLUSIVE_o <= 1'b1;
              lock_id         <= data_ID1_i;
            end else begin
              RR_FLAG_o <= 1'b0;
            end
          end
        end
        LOCKED: begin
          if (rsp_match) begin
            state     <= IDLE;
            RR_FLAG_o <= ~SEL_EXCLUSIVE_o;
          end else if (expired) begin
            state     <= IDLE;
            RR_FLAG_o <= ~SEL_EXCLUSIVE_o;
            timeout_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign lock_EXCLUSIVE_o = (state == LOCKED);

endmodule : axi_excl_lock_ctrl

`default_nettype wire
